// File: rtl/fft8_pkg.sv
// Shared constants, state encodings and address helpers for the 8-point FFT sequencer.
package fft8_pkg;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;

  typedef struct packed {
    logic [2:0] top;
    logic [2:0] bot;
    logic [2:0] k;
  } bfly_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Radix-2 DIT addressing; odd ops reuse the pair with the negated twiddle (k+4).
  function automatic bfly_t bfly_addr(input logic [1:0] stage, input logic [2:0] op);
    bfly_t      r;
    logic [1:0] j;
    j = op[2:1];
    case (stage)
      2'd0: begin
        r.top = {j, 1'b0};
        r.bot = {j, 1'b1};
        r.k   = 3'd0;
      end
      2'd1: begin
        r.top = {j[1], 1'b0, j[0]};
        r.bot = {j[1], 1'b1, j[0]};
        r.k   = {1'b0, j[0], 1'b0};
      end
      default: begin
        r.top = {1'b0, j};
        r.bot = {1'b1, j};
        r.k   = {1'b0, j};
      end
    endcase
    r.k[2] = op[0];
    return r;
  endfunction

endpackage

// File: rtl/fft8_tag_pipe.sv
// Delay line carrying {valid, dest} alongside the MAD unit so results land in the right slot.
module fft8_tag_pipe #(
  parameter int unsigned MAD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic [2:0] in_dest,
  output logic       out_vld,
  output logic [2:0] out_dest
);

  logic [MAD_LAT-1:0] vld_q, vld_d;
  logic [2:0]         dest_q [MAD_LAT];
  logic [2:0]         dest_d [MAD_LAT];

  always_comb begin
    vld_d     = '0;
    dest_d    = dest_q;
    vld_d[0]  = in_vld;
    dest_d[0] = in_dest;
    for (int i = 1; i < MAD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      dest_d[i] = dest_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    dest_q <= dest_d;
  end

  assign out_vld  = vld_q[MAD_LAT-1];
  assign out_dest = dest_q[MAD_LAT-1];

endmodule

// File: rtl/fft8_mad_sequencer.sv
// Frame controller for an 8-point FFT: loads bit-reversed samples, issues 3 stages of
// butterfly operand pairs to an external complex MAD unit, then streams X[0..7] out.
module fft8_mad_sequencer
  import fft8_pkg::*;
#(
  parameter int unsigned MAD_LAT = 1,
  parameter int unsigned W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] mad_num1,
  output logic [W-1:0] mad_num2,
  output logic [2:0]   mad_twiddle,
  input  logic [W-1:0] mad_result,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned DW = (MAD_LAT > 1) ? $clog2(MAD_LAT) : 1;

  logic [1:0]    state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;

  logic [W-1:0]  bank_a_q [8];
  logic [W-1:0]  bank_b_q [8];

  bfly_t         ba;
  logic          src_is_b;
  logic          tag_vld;
  logic [2:0]    tag_dest;
  logic          a_we, b_we;
  logic [2:0]    wr_addr;
  logic [W-1:0]  wr_data;

  assign ba       = bfly_addr(stage_q, cnt_q);
  assign src_is_b = stage_q[0];

  fft8_tag_pipe #(.MAD_LAT(MAD_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (state_q == ST_ISSUE),
    .in_dest  (cnt_q[0] ? ba.bot : ba.top),
    .out_vld  (tag_vld),
    .out_dest (tag_dest)
  );

  // cnt_q is the sample index in LOAD, the op index in ISSUE and m in UNLOAD.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_ISSUE;
            stage_d = 2'd0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(MAD_LAT - 1)) begin
          cnt_d = 3'd0;
          if (stage_q == 2'd2) begin
            state_d = ST_UNLOAD;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + 2'd1;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: begin
        if (out_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      stage_q <= 2'd0;
      cnt_q   <= 3'd0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Loads only touch bank A; MAD results go to whichever bank the current stage is not reading.
  always_comb begin
    a_we    = 1'b0;
    b_we    = 1'b0;
    wr_addr = 3'd0;
    wr_data = mad_result;
    if (state_q == ST_LOAD && in_valid) begin
      a_we    = 1'b1;
      wr_addr = bitrev3(cnt_q);
      wr_data = in_data;
    end else if (tag_vld) begin
      wr_addr = tag_dest;
      a_we    = src_is_b;
      b_we    = !src_is_b;
    end
  end

  always_ff @(posedge clk) begin
    if (a_we) bank_a_q[wr_addr] <= wr_data;
    if (b_we) bank_b_q[wr_addr] <= wr_data;
  end

  always_comb begin
    mad_num1    = '0;
    mad_num2    = '0;
    mad_twiddle = 3'd0;
    out_data    = '0;
    if (state_q == ST_ISSUE) begin
      mad_num1    = src_is_b ? bank_b_q[ba.top] : bank_a_q[ba.top];
      mad_num2    = src_is_b ? bank_b_q[ba.bot] : bank_a_q[ba.bot];
      mad_twiddle = ba.k;
    end
    if (state_q == ST_UNLOAD) out_data = bank_b_q[cnt_q];
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_LOAD);
  assign out_valid = (state_q == ST_UNLOAD);

endmodule

// File: tb/tb_fft8_mad_sequencer.sv
// Bench: two sequencer instances (MAD_LAT=1 and 3), each fed by a behavioural complex MAD,
// checked against an array-level radix-2 DIT reference model.
module tb_fft8_mad_sequencer;

  typedef logic [31:0] frame_t [8];

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] in_data;
  bit          sel;
  bit          fp_mode;
  int          lat;
  int          checks = 0;
  int          errors = 0;

  logic        ir_w [2];
  logic        ov_w [2];
  logic        bz_w [2];
  logic [31:0] n1_w [2];
  logic [31:0] n2_w [2];
  logic [2:0]  tw_w [2];
  logic [31:0] od_w [2];
  logic [31:0] res1_q;
  logic [31:0] res3_q [3];

  logic [31:0] tr_n1 [24];
  logic [31:0] tr_n2 [24];
  logic [2:0]  tr_k  [24];

  always #5 clk = ~clk;

  fft8_mad_sequencer #(.MAD_LAT(1), .W(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_data(in_data), .in_ready(ir_w[0]),
    .mad_num1(n1_w[0]), .mad_num2(n2_w[0]), .mad_twiddle(tw_w[0]), .mad_result(res1_q),
    .out_valid(ov_w[0]), .out_data(od_w[0]), .out_ready(out_ready && !sel), .busy(bz_w[0])
  );

  fft8_mad_sequencer #(.MAD_LAT(3), .W(32)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_data(in_data), .in_ready(ir_w[1]),
    .mad_num1(n1_w[1]), .mad_num2(n2_w[1]), .mad_twiddle(tw_w[1]), .mad_result(res3_q[2]),
    .out_valid(ov_w[1]), .out_data(od_w[1]), .out_ready(out_ready && sel), .busy(bz_w[1])
  );

  wire        o_in_ready  = sel ? ir_w[1] : ir_w[0];
  wire        o_out_valid = sel ? ov_w[1] : ov_w[0];
  wire        o_busy      = sel ? bz_w[1] : bz_w[0];
  wire [31:0] o_n1        = sel ? n1_w[1] : n1_w[0];
  wire [31:0] o_n2        = sel ? n2_w[1] : n2_w[0];
  wire [2:0]  o_tw        = sel ? tw_w[1] : tw_w[0];
  wire [31:0] o_out_data  = sel ? od_w[1] : od_w[0];

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e, m;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 0) v = m * (2.0 ** (-24));
    else        v = (1024 + m) * (2.0 ** (e - 25));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    logic [63:0] b;
    logic        s;
    real         a;
    int          e, m;
    b = $realtobits(v);
    s = b[63];
    a = s ? -v : v;
    if (a == 0.0) return {s, 15'd0};
    e = 15;
    while (a >= 2.0 && e < 31) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    if (e >= 31) return {s, 5'h1f, 10'd0};
    if (a < 1.0) begin
      m = $rtoi(a * 1024.0 + 0.5);
      return {s, (m >= 1024) ? 5'd1 : 5'd0, 10'(m)};
    end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m >= 1024) begin m = 0; e++; end
    return {s, 5'(e), 10'(m)};
  endfunction

  // a + W8^k * b, W8 = exp(-j*2*pi/8); hash mode gives an order/twiddle sensitive tracer.
  function automatic logic [31:0] mad_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] k);
    real r, c, s, pr, pi;
    if (!fp_mode)
      return a * 32'h9E3779B1 + (b ^ {k, 29'd0}) * 32'h85EBCA6B + {29'd0, k};
    r = 0.7071067811865476;
    case (k)
      3'd0: begin c = 1.0;  s = 0.0;  end
      3'd1: begin c = r;    s = -r;   end
      3'd2: begin c = 0.0;  s = -1.0; end
      3'd3: begin c = -r;   s = -r;   end
      3'd4: begin c = -1.0; s = 0.0;  end
      3'd5: begin c = -r;   s = r;    end
      3'd6: begin c = 0.0;  s = 1.0;  end
      default: begin c = r; s = r;    end
    endcase
    pr = c * h2r(b[31:16]) - s * h2r(b[15:0]);
    pi = c * h2r(b[15:0]) + s * h2r(b[31:16]);
    return {r2h(h2r(a[31:16]) + pr), r2h(h2r(a[15:0]) + pi)};
  endfunction

  always @(posedge clk) begin
    res1_q    <= mad_f(n1_w[0], n2_w[0], tw_w[0]);
    res3_q[0] <= mad_f(n1_w[1], n2_w[1], tw_w[1]);
    res3_q[1] <= res3_q[0];
    res3_q[2] <= res3_q[1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Textbook in-place DIT: bit-reversed load, then log2(8) passes of groups and butterflies.
  task automatic ref_model(input frame_t x, output frame_t y);
    logic [31:0] cur [8];
    logic [31:0] nxt [8];
    int n, span, t, u, k;
    n = 0;
    for (int i = 0; i < 8; i++) cur[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)] = x[i];
    for (int s = 0; s < 3; s++) begin
      span = 1 << s;
      for (int g = 0; g < (4 >> s); g++) begin
        for (int p = 0; p < span; p++) begin
          t = g * 2 * span + p;
          u = t + span;
          k = p * (4 >> s);
          tr_n1[n] = cur[t]; tr_n2[n] = cur[u]; tr_k[n] = 3'(k);     n++;
          tr_n1[n] = cur[t]; tr_n2[n] = cur[u]; tr_k[n] = 3'(k + 4); n++;
          nxt[t] = mad_f(cur[t], cur[u], 3'(k));
          nxt[u] = mad_f(cur[t], cur[u], 3'(k + 4));
        end
      end
      cur = nxt;
    end
    for (int i = 0; i < 8; i++) y[i] = cur[i];
  endtask

  task automatic load_frame(input frame_t x, input bit hold);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = x[i];
      chk("in_ready_load", {31'd0, o_in_ready}, 32'd1);
      tick();
    end
    in_valid = hold;
    in_data  = hold ? $urandom : 32'd0;
  endtask

  task automatic run_frame(input frame_t x, input frame_t exp, input bit trace, input bit bp, input bit hold);
    int          m, cyc, s, o;
    logic [31:0] prev;
    bit          stalled;
    load_frame(x, hold);
    for (int c = 0; c < 3 * (8 + lat); c++) begin
      s = c / (8 + lat);
      o = c % (8 + lat);
      chk("busy_compute", {31'd0, o_busy}, 32'd1);
      chk("in_ready_compute", {31'd0, o_in_ready}, 32'd0);
      chk("out_valid_compute", {31'd0, o_out_valid}, 32'd0);
      if (trace && o < 8) begin
        chk($sformatf("num1_s%0d_op%0d", s, o), o_n1, tr_n1[s*8+o]);
        chk($sformatf("num2_s%0d_op%0d", s, o), o_n2, tr_n2[s*8+o]);
        chk($sformatf("twiddle_s%0d_op%0d", s, o), {29'd0, o_tw}, {29'd0, tr_k[s*8+o]});
      end
      if (hold) in_data = $urandom;
      tick();
    end
    chk("out_valid_after_compute", {31'd0, o_out_valid}, 32'd1);
    m = 0; cyc = 0; stalled = 0; prev = 32'd0;
    while (m < 8 && cyc < 40) begin
      out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
      if (hold) in_data = $urandom;
      chk("out_valid_unload", {31'd0, o_out_valid}, 32'd1);
      if (stalled) chk("stall_stable", o_out_data, prev);
      chk($sformatf("X%0d", m), o_out_data, exp[m]);
      stalled = !out_ready;
      prev    = o_out_data;
      if (o_out_valid === 1'b1 && out_ready) m++;
      cyc++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("unload_count", 32'(m), 32'd8);
    chk("out_valid_end", {31'd0, o_out_valid}, 32'd0);
    chk("in_ready_end", {31'd0, o_in_ready}, 32'd1);
    chk("busy_end", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    frame_t x, y, imp, imp_exp, cst, cst_exp;
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    sel = 1'b0; fp_mode = 1'b0; lat = 1;
    for (int i = 0; i < 8; i++) begin
      imp[i]     = (i == 0) ? 32'h3C000000 : 32'h0;
      imp_exp[i] = 32'h3C000000;
      cst[i]     = 32'h3C000000;
      cst_exp[i] = (i == 0) ? 32'h48000000 : 32'h0;
    end
    repeat (2) tick();
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_num1", o_n1, 32'd0);
    chk("rst_num2", o_n2, 32'd0);
    chk("rst_twiddle", {29'd0, o_tw}, 32'd0);
    chk("rst_out_data", o_out_data, 32'd0);
    rst = 1'b0;
    tick();

    for (int si = 0; si < 2; si++) begin
      sel = (si == 1);
      lat = (si == 1) ? 3 : 1;

      fp_mode = 1'b1;
      run_frame(imp, imp_exp, 1'b0, 1'b0, 1'b0);
      run_frame(cst, cst_exp, 1'b0, 1'b0, 1'b0);

      fp_mode = 1'b0;
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < 8; i++) x[i] = $urandom;
        ref_model(x, y);
        run_frame(x, y, 1'b1, 1'b0, 1'b0);
      end

      for (int i = 0; i < 8; i++) x[i] = $urandom;
      ref_model(x, y);
      run_frame(x, y, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) x[i] = $urandom;
      ref_model(x, y);
      run_frame(x, y, 1'b1, 1'b0, 1'b0);

      // Abort in the middle of stage 1, then a clean impulse frame.
      fp_mode = 1'b1;
      load_frame(imp, 1'b0);
      repeat (8 + lat + 3) tick();
      rst = 1'b1;
      #1;
      chk("abort_in_ready", {31'd0, o_in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, o_out_valid}, 32'd0);
      chk("abort_busy", {31'd0, o_busy}, 32'd0);
      chk("abort_twiddle", {29'd0, o_tw}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      run_frame(imp, imp_exp, 1'b0, 1'b0, 1'b0);

      fp_mode = 1'b0;
      for (int i = 0; i < 8; i++) x[i] = $urandom;
      ref_model(x, y);
      run_frame(x, y, 1'b1, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
